// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - requester and RAM-side signal bundle for ram_arbiter
interface ram_arbiter_if #(
    parameter int WORD_W = 32
);
    logic              d_ren;
    logic              d_wen;
    logic [WORD_W-1:0] d_addr;
    logic [WORD_W-1:0] d_store;
    logic [WORD_W-1:0] d_load;
    logic              d_wait;
    logic [1:0]        i_ren;
    logic [WORD_W-1:0] i_addr0;
    logic [WORD_W-1:0] i_addr1;
    logic [WORD_W-1:0] i_load;
    logic [1:0]        i_wait;
    logic              ram_ren;
    logic              ram_wen;
    logic [WORD_W-1:0] ram_addr;
    logic [WORD_W-1:0] ram_store;
    logic [WORD_W-1:0] ram_load;
    logic [1:0]        ram_state;

    // Arbiter view
    modport slave (
        input  d_ren, d_wen, d_addr, d_store, i_ren, i_addr0, i_addr1,
               ram_load, ram_state,
        output d_load, d_wait, i_load, i_wait,
               ram_ren, ram_wen, ram_addr, ram_store
    );

    // Requesters plus RAM view
    modport master (
        output d_ren, d_wen, d_addr, d_store, i_ren, i_addr0, i_addr1,
               ram_load, ram_state,
        input  d_load, d_wait, i_load, i_wait,
               ram_ren, ram_wen, ram_addr, ram_store
    );
endinterface

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - single RAM port arbiter: data priority, round-robin fetch, starvation cap
module ram_arbiter #(
    parameter int WORD_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          CLK,
    input  logic          RST,
    ram_arbiter_if.slave  bus
);
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_D = 2'd1,
        GRANT_I = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       gnt_core_q, gnt_core_d;
    logic       rr_ptr_q, rr_ptr_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;

    logic       d_req;
    logic       i_any;
    logic       i_pick;
    logic       access;

    assign d_req  = bus.d_ren | bus.d_wen;
    assign i_any  = |bus.i_ren;
    assign i_pick = (&bus.i_ren) ? rr_ptr_q : bus.i_ren[1];
    assign access = (bus.ram_state == RAM_ACCESS);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            gnt_core_q   <= 1'b0;
            rr_ptr_q     <= 1'b0;
            starve_cnt_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            gnt_core_q   <= gnt_core_d;
            rr_ptr_q     <= rr_ptr_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        gnt_core_d    = gnt_core_q;
        rr_ptr_d      = rr_ptr_q;
        starve_cnt_d  = starve_cnt_q;
        bus.ram_ren   = 1'b0;
        bus.ram_wen   = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_store = '0;
        bus.d_load    = '0;
        bus.d_wait    = 1'b1;
        bus.i_load    = '0;
        bus.i_wait    = 2'b11;

        unique case (state_q)
            IDLE: begin
                if ((starve_cnt_q == STARVE_LIM) && i_any) begin
                    state_d    = GRANT_I;
                    gnt_core_d = i_pick;
                end else if (d_req) begin
                    state_d = GRANT_D;
                end else if (i_any) begin
                    state_d    = GRANT_I;
                    gnt_core_d = i_pick;
                end
            end

            GRANT_D: begin
                // Completion takes precedence over a withdrawn request in the same cycle
                if (access || d_req) begin
                    bus.ram_addr  = bus.d_addr;
                    bus.ram_store = bus.d_store;
                    bus.ram_wen   = bus.d_wen;
                    bus.ram_ren   = ~bus.d_wen;
                end
                if (access) begin
                    bus.d_wait = 1'b0;
                    bus.d_load = bus.ram_load;
                    state_d    = IDLE;
                    if (!i_any) begin
                        starve_cnt_d = 4'd0;
                    end else if (starve_cnt_q < STARVE_LIM) begin
                        starve_cnt_d = starve_cnt_q + 4'd1;
                    end
                end else if (!d_req) begin
                    state_d = IDLE;
                end
            end

            GRANT_I: begin
                if (access || bus.i_ren[gnt_core_q]) begin
                    bus.ram_ren  = 1'b1;
                    bus.ram_addr = gnt_core_q ? bus.i_addr1 : bus.i_addr0;
                end
                if (access) begin
                    bus.i_wait[gnt_core_q] = 1'b0;
                    bus.i_load   = bus.ram_load;
                    rr_ptr_d     = ~gnt_core_q;
                    starve_cnt_d = 4'd0;
                    state_d      = IDLE;
                end else if (!bus.i_ren[gnt_core_q]) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end
endmodule
